// File: rtl/serial_adder_fsm_if.sv
// ============================================================================
// Module      : serial_adder_fsm_if
// Description : Request/result bundle for the bit-serial adder. The optional
//               i_sub request bit exists only when SERIAL_ADDER_SUB_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_adder_fsm_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             i_sub;
`endif
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output i_start, i_a, i_b, i_cin, i_sub,
                  input  o_busy, o_done, o_sum, o_cout);
  modport slave  (input  i_start, i_a, i_b, i_cin, i_sub,
                  output o_busy, o_done, o_sum, o_cout);
`else
  modport master (output i_start, i_a, i_b, i_cin,
                  input  o_busy, o_done, o_sum, o_cout);
  modport slave  (input  i_start, i_a, i_b, i_cin,
                  output o_busy, o_done, o_sum, o_cout);
`endif
endinterface

`default_nettype wire

// File: rtl/serial_adder_fsm.sv
// ============================================================================
// Module      : serial_adder_fsm
// Description : Bit-serial N-bit adder, one bit per clock, LSB first.
//               SERIAL_ADDER_SUB_EN adds a subtract mode (a + ~b + 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_adder_fsm_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-2:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;
  logic             w_ha1_s;
  logic             w_ha1_c;
  logic             w_ha2_c;
  logic             w_sum_bit;
  logic             w_carry_nxt;
  logic [WIDTH-1:0] w_cat;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load = bus.i_sub ? ~bus.i_b : bus.i_b;
  assign w_c_load = bus.i_sub ? 1'b1 : bus.i_cin;
`else
  assign w_b_load = bus.i_b;
  assign w_c_load = bus.i_cin;
`endif

  // Full adder built from two half adders and an OR for the carry
  assign w_ha1_s     = r_a[0] ^ r_b[0];
  assign w_ha1_c     = r_a[0] & r_b[0];
  assign w_sum_bit   = w_ha1_s ^ r_carry;
  assign w_ha2_c     = w_ha1_s & r_carry;
  assign w_carry_nxt = w_ha1_c | w_ha2_c;

  // New bit enters at the MSB; on the last bit this is the complete sum
  assign w_cat = {w_sum_bit, r_acc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.i_start) begin
            r_a     <= bus.i_a;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_BUSY;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_acc   <= w_cat[WIDTH-1:1];
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_carry_nxt;
          if (r_cnt == c_LAST) begin
            r_sum   <= w_cat;
            r_cout  <= w_carry_nxt;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
  assign bus.o_sum  = r_sum;
  assign bus.o_cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_fsm.sv
// ============================================================================
// Module      : tb_serial_adder_fsm
// Description : Directed self-checking bench for serial_adder_fsm (WIDTH=8);
//               subtract vectors run when SERIAL_ADDER_SUB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_fsm;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  serial_adder_fsm_if #(.WIDTH(WIDTH)) bus ();

  serial_adder_fsm #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic tc, input logic ts);
    bus.i_start = st;
    bus.i_a     = ta;
    bus.i_b     = tb_v;
    bus.i_cin   = tc;
`ifdef SERIAL_ADDER_SUB_EN
    bus.i_sub   = ts;
`else
    if (ts) $display("note: sub request ignored in add-only build");
`endif
  endtask

  // One full operation from IDLE: latency, busy width, no partial results, result, strobe width
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tc, input logic ts, input logic [7:0] esum, input logic ecout);
    logic [7:0] prev_sum;
    int         edges;
    int         busy_cnt;
    logic       stable;
    prev_sum = bus.o_sum;
    drive(1'b1, ta, tb_v, tc, ts);
    tick();
    bus.i_start = 1'b0;
    edges = 0; busy_cnt = 0; stable = 1'b1;
    while (!bus.o_done && edges < 20) begin
      if (bus.o_busy) busy_cnt++;
      if (bus.o_sum !== prev_sum) stable = 1'b0;
      tick();
      edges++;
    end
    check({tag, "_latency"}, edges, 8);
    check({tag, "_busy_cycles"}, busy_cnt, 8);
    check({tag, "_no_partial"}, {31'd0, stable}, 1);
    check({tag, "_sum"}, {24'd0, bus.o_sum}, {24'd0, esum});
    check({tag, "_cout"}, {31'd0, bus.o_cout}, {31'd0, ecout});
    tick();
    check({tag, "_done_1cyc"}, {31'd0, bus.o_done}, 0);
  endtask

  initial begin
    int e;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_busy", {31'd0, bus.o_busy}, 0);
    check("rst_done", {31'd0, bus.o_done}, 0);
    check("rst_sum",  {24'd0, bus.o_sum}, 0);
    check("rst_cout", {31'd0, bus.o_cout}, 0);
    rst_n = 1'b1;
    tick();

    // Plain adds
    run_op("t1", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0);
    run_op("t2a", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_op("t2b", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

    // start and operand changes during BUSY are ignored
    drive(1'b1, 8'h12, 8'h34, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    e = 1;
    tick(); tick(); e = 3;
    drive(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
    tick(); e = 4;
    bus.i_start = 1'b0;
    while (!bus.o_done && e < 20) begin
      tick();
      e++;
    end
    check("t3_latency", e, 9);
    check("t3_sum",  {24'd0, bus.o_sum}, 32'h47);
    check("t3_cout", {31'd0, bus.o_cout}, 0);
    drive(1'b0, 8'hAA, 8'h55, 1'b1, 1'b0);
    repeat (3) tick();
    check("t3_hold_sum", {24'd0, bus.o_sum}, 32'h47);
    check("t3_idle_busy", {31'd0, bus.o_busy}, 0);

    // Back-to-back: start held high through DONE
    drive(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
    tick();
    bus.i_a = 8'h10;
    bus.i_b = 8'h20;
    e = 0;
    while (!bus.o_done && e < 20) begin
      tick();
      e++;
    end
    check("t4_first_latency", e, 8);
    check("t4_first_sum", {24'd0, bus.o_sum}, 32'h03);
    tick();
    check("t4_done_drop", {31'd0, bus.o_done}, 0);
    check("t4_busy_again", {31'd0, bus.o_busy}, 1);
    bus.i_start = 1'b0;
    e = 1;
    while (!bus.o_done && e < 20) begin
      tick();
      e++;
    end
    check("t4_spacing", e, 9);
    check("t4_second_sum", {24'd0, bus.o_sum}, 32'h30);

    // Asynchronous reset in the middle of an operation
    tick();
    drive(1'b1, 8'h0F, 8'hF1, 1'b0, 1'b0);
    tick();
    bus.i_start = 1'b0;
    repeat (4) tick();
    check("t5_busy_before_rst", {31'd0, bus.o_busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", {31'd0, bus.o_busy}, 0);
    check("t5_rst_sum",  {24'd0, bus.o_sum}, 0);
    check("t5_rst_done", {31'd0, bus.o_done}, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("t5_idle_after_rst", {31'd0, bus.o_busy}, 0);
    run_op("t5_post", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op("t6a", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    run_op("t6b", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
    run_op("t6c", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
